// File: rtl/clock_set_controller.sv
`default_nettype none
// -----------------------------------------------------------------------------
// clock_set_controller : time-of-day counters, button-driven set FSM and alarm
// gating, all driven by edges of synchronised divided clocks.
// Revision: 1.0
// -----------------------------------------------------------------------------
module clock_set_controller #(
    parameter int ALARM_TIMEOUT = 60,
    parameter int TIMEOUT_BITS  = 7
) (
    input  logic       clk_FPGA,
    input  logic       reset,
    input  logic [3:0] clock_circuit_control,
    input  logic       btn_mode,
    input  logic       btn_plus,
    input  logic       btn_stop,
    input  logic       alarm_en,
    output logic [4:0] ore,
    output logic [5:0] minute,
    output logic [5:0] secunde,
    output logic [4:0] alarm_ore,
    output logic [5:0] alarm_min,
    output logic [2:0] mode,
    output logic       blink,
    output logic       alarm_active,
    output logic       buzzer
);

    localparam logic [2:0] S_RUN    = 3'd0;
    localparam logic [2:0] S_SET_H  = 3'd1;
    localparam logic [2:0] S_SET_M  = 3'd2;
    localparam logic [2:0] S_SET_AH = 3'd3;
    localparam logic [2:0] S_SET_AM = 3'd4;
    localparam logic [TIMEOUT_BITS-1:0] c_TIMEOUT_LAST = TIMEOUT_BITS'(ALARM_TIMEOUT - 1);

    logic [7:0] w_in;
    logic [7:0] r_sync1;
    logic [7:0] r_sync2;
    logic [4:0] r_prev;
    logic       w_tick_1hz, w_tick_2hz, w_mode_p, w_plus_p, w_stop_p;
    logic       w_plus_s, w_en_s, w_tone_s, w_unused;

    logic [2:0] r_state, w_state_next;
    logic       w_counting, w_setting;

    logic [4:0] r_hr, r_al_hr;
    logic [5:0] r_min, r_sec, r_al_min;
    logic       r_blink, r_active, r_buzzer;
    logic [TIMEOUT_BITS-1:0] r_tcnt;

    logic [4:0] w_hr_inc, w_al_hr_inc, w_new_hr;
    logic [5:0] w_min_inc, w_sec_inc, w_al_min_inc, w_new_min;
    logic       w_sec_wrap, w_min_wrap, w_tick_time, w_inc;
    logic       w_trig, w_clear, w_active_next;

    assign w_in = {alarm_en, btn_stop, btn_plus, btn_mode, clock_circuit_control};

    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= w_in;
            r_sync2 <= r_sync1;
            r_prev  <= {r_sync2[6:4], r_sync2[1:0]};
        end
    end

    assign w_tick_2hz = r_sync2[0] & ~r_prev[0];
    assign w_tick_1hz = r_sync2[1] & ~r_prev[1];
    assign w_mode_p   = r_sync2[4] & ~r_prev[2];
    assign w_plus_p   = r_sync2[5] & ~r_prev[3];
    assign w_stop_p   = r_sync2[6] & ~r_prev[4];
    assign w_plus_s   = r_sync2[5];
    assign w_en_s     = r_sync2[7];
    assign w_tone_s   = r_sync2[3];
    // The 1 kHz display clock is synchronised with the bundle but not consumed here.
    assign w_unused   = r_sync2[2];

    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_mode_p) begin
            case (r_state)
                S_RUN:    w_state_next = S_SET_H;
                S_SET_H:  w_state_next = S_SET_M;
                S_SET_M:  w_state_next = S_SET_AH;
                S_SET_AH: w_state_next = S_SET_AM;
                default:  w_state_next = S_RUN;
            endcase
        end
    end

    always_comb begin
        mode       = r_state;
        w_counting = (r_state == S_RUN) || (r_state == S_SET_AH) || (r_state == S_SET_AM);
        w_setting  = (r_state != S_RUN);
    end

    assign w_sec_wrap   = (r_sec == 6'd59);
    assign w_min_wrap   = (r_min == 6'd59);
    assign w_sec_inc    = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
    assign w_min_inc    = w_min_wrap ? 6'd0 : r_min + 6'd1;
    assign w_hr_inc     = (r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1;
    assign w_al_hr_inc  = (r_al_hr == 5'd23) ? 5'd0 : r_al_hr + 5'd1;
    assign w_al_min_inc = (r_al_min == 6'd59) ? 6'd0 : r_al_min + 6'd1;
    assign w_tick_time  = w_tick_1hz & w_counting;
    // A coincident press and repeat tick collapse into a single increment.
    assign w_inc        = w_setting & (w_plus_p | (w_plus_s & w_tick_2hz));

    assign w_new_min = w_sec_wrap ? w_min_inc : r_min;
    assign w_new_hr  = (w_sec_wrap & w_min_wrap) ? w_hr_inc : r_hr;

    assign w_trig  = w_tick_time & w_sec_wrap & w_en_s &
                     (w_new_hr == r_al_hr) & (w_new_min == r_al_min);
    assign w_clear = w_stop_p | ~w_en_s |
                     (r_active & w_tick_1hz & (r_tcnt == c_TIMEOUT_LAST));
    assign w_active_next = w_clear ? 1'b0 : (w_trig ? 1'b1 : r_active);

    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            r_hr     <= '0;
            r_min    <= '0;
            r_sec    <= '0;
            r_al_hr  <= '0;
            r_al_min <= '0;
        end else begin
            if (w_tick_time) begin
                r_sec <= w_sec_inc;
                if (w_sec_wrap) begin
                    r_min <= w_min_inc;
                    if (w_min_wrap) begin
                        r_hr <= w_hr_inc;
                    end
                end
            end
            if (w_inc && (r_state == S_SET_H)) begin
                r_hr <= w_hr_inc;
            end
            if (w_inc && (r_state == S_SET_M)) begin
                r_min <= w_min_inc;
            end
            if (w_mode_p && (r_state == S_SET_M)) begin
                r_sec <= 6'd0;
            end
            if (w_inc && (r_state == S_SET_AH)) begin
                r_al_hr <= w_al_hr_inc;
            end
            if (w_inc && (r_state == S_SET_AM)) begin
                r_al_min <= w_al_min_inc;
            end
        end
    end

    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            r_blink  <= 1'b0;
            r_active <= 1'b0;
            r_tcnt   <= '0;
            r_buzzer <= 1'b0;
        end else begin
            if (w_mode_p || !w_setting) begin
                r_blink <= 1'b0;
            end else if (w_tick_2hz) begin
                r_blink <= ~r_blink;
            end
            r_active <= w_active_next;
            if (!w_clear && w_trig) begin
                r_tcnt <= '0;
            end else if (r_active && w_tick_1hz) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            // Gate with the next alarm state so the tone stops in the same cycle.
            r_buzzer <= w_tone_s & w_active_next;
        end
    end

    assign ore          = r_hr;
    assign minute       = r_min;
    assign secunde      = r_sec;
    assign alarm_ore    = r_al_hr;
    assign alarm_min    = r_al_min;
    assign blink        = r_blink;
    assign alarm_active = r_active;
    assign buzzer       = r_buzzer;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_controller.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_clock_set_controller : randomized and directed checks against a
// seconds-of-day reference model.
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_clock_set_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ccc;
    logic       bm, bp, bs, en;
    logic [4:0] ore, alarm_ore;
    logic [5:0] minute, secunde, alarm_min;
    logic [2:0] mode;
    logic       blink, alarm_active, buzzer;
    logic [33:0] obs;

    int checks = 0;
    int errors = 0;

    int m_tod, m_ah, m_am, m_mode, m_cnt;
    bit m_blink, m_active, m_en, m_plus, m_tone;

    always #5 clk = ~clk;

    clock_set_controller #(.ALARM_TIMEOUT(60), .TIMEOUT_BITS(7)) dut (
        .clk_FPGA(clk), .reset(rst_n), .clock_circuit_control(ccc),
        .btn_mode(bm), .btn_plus(bp), .btn_stop(bs), .alarm_en(en),
        .ore(ore), .minute(minute), .secunde(secunde),
        .alarm_ore(alarm_ore), .alarm_min(alarm_min), .mode(mode),
        .blink(blink), .alarm_active(alarm_active), .buzzer(buzzer)
    );

    assign obs = {ore, minute, secunde, alarm_ore, alarm_min, mode, blink, alarm_active, buzzer};

    function automatic logic [33:0] exp_vec();
        int h, mi, s;
        h  = m_tod / 3600;
        mi = (m_tod / 60) % 60;
        s  = m_tod % 60;
        return {5'(h), 6'(mi), 6'(s), 5'(m_ah), 6'(m_am), 3'(m_mode),
                m_blink, m_active, m_active & m_tone};
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_tod = 0; m_ah = 0; m_am = 0; m_mode = 0; m_cnt = 0;
        m_blink = 0; m_active = 0; m_en = 0; m_plus = 0; m_tone = 0;
    endtask

    task automatic inc_field();
        int h, mi, s;
        h  = m_tod / 3600;
        mi = (m_tod / 60) % 60;
        s  = m_tod % 60;
        case (m_mode)
            1: m_tod = ((h + 1) % 24) * 3600 + mi * 60 + s;
            2: m_tod = h * 3600 + ((mi + 1) % 60) * 60 + s;
            3: m_ah  = (m_ah + 1) % 24;
            4: m_am  = (m_am + 1) % 60;
            default: ;
        endcase
    endtask

    task automatic model_tick1();
        bit clr, trig;
        clr  = 0;
        trig = 0;
        if (m_active) begin
            m_cnt++;
            clr = (m_cnt == 60);
        end
        if (m_mode == 0 || m_mode == 3 || m_mode == 4) begin
            m_tod = (m_tod + 1) % 86400;
            trig  = (m_tod % 60 == 0) && (m_tod / 60 == m_ah * 60 + m_am) && m_en;
        end
        if (clr) m_active = 0;
        else if (trig) begin
            m_active = 1;
            m_cnt    = 0;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        ccc = 4'd0; bm = 0; bp = 0; bs = 0; en = 0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);
        model_reset();
    endtask

    task automatic do_tick1();
        ccc[1] = 1'b1; wait_cyc(6);
        ccc[1] = 1'b0; wait_cyc(6);
        model_tick1();
    endtask

    task automatic do_tick2();
        ccc[0] = 1'b1; wait_cyc(6);
        ccc[0] = 1'b0; wait_cyc(6);
        if (m_mode != 0) begin
            m_blink = !m_blink;
            if (m_plus) inc_field();
        end
    endtask

    task automatic press_mode();
        bm = 1'b1; wait_cyc(6);
        bm = 1'b0; wait_cyc(6);
        if (m_mode == 2) m_tod = m_tod - (m_tod % 60);
        m_mode  = (m_mode + 1) % 5;
        m_blink = 0;
    endtask

    task automatic plus_down();
        bp = 1'b1; wait_cyc(12);
        m_plus = 1;
        if (m_mode != 0) inc_field();
    endtask

    task automatic plus_up();
        bp = 1'b0; wait_cyc(12);
        m_plus = 0;
    endtask

    task automatic press_plus();
        plus_down();
        plus_up();
    endtask

    task automatic press_stop();
        bs = 1'b1; wait_cyc(6);
        bs = 1'b0; wait_cyc(6);
        m_active = 0;
    endtask

    task automatic set_en(input bit v);
        en = v; wait_cyc(12);
        m_en = v;
        if (!v) m_active = 0;
    endtask

    task automatic set_tone(input bit v);
        ccc[3] = v; wait_cyc(12);
        m_tone = v;
    endtask

    // Walks the set FSM from a freshly reset clock to load time and alarm.
    task automatic set_all(input int h, input int mi, input int ah, input int am);
        press_mode();
        repeat (h) press_plus();
        press_mode();
        repeat (mi) press_plus();
        press_mode();
        repeat (ah) press_plus();
        press_mode();
        repeat (am) press_plus();
        press_mode();
    endtask

    task automatic alarm_setup(input bit v);
        apply_reset();
        set_all(7, 29, 7, 30);
        set_en(v);
        repeat (59) do_tick1();
        checks++;
        if ({ore, minute, secunde, alarm_active} !== {5'd7, 6'd29, 6'd59, 1'b0}) begin
            errors++;
            $display("FAIL alarm_setup: got %0d:%0d:%0d act=%0b expected 7:29:59 act=0",
                     ore, minute, secunde, alarm_active);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (obs !== 34'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, 34'd0);
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_count();
        apply_reset();
        for (int i = 0; i < 61; i++) begin
            do_tick1();
            checks++;
            if (buzzer !== 1'b0) begin
                errors++;
                $display("FAIL count_buzzer: tick %0d got %b expected 0", i, buzzer);
            end
        end
        checks++;
        if ({ore, minute, secunde, mode} !== {5'd0, 6'd1, 6'd1, 3'd0}) begin
            errors++;
            $display("FAIL count_61: got %0d:%0d:%0d mode %0d expected 0:1:1 mode 0",
                     ore, minute, secunde, mode);
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL count_model: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_preload_rollover();
        logic [16:0] t;
        apply_reset();
        set_all(23, 59, 0, 0);
        checks++;
        if ({ore, minute, secunde, mode} !== {5'd23, 6'd59, 6'd0, 3'd0}) begin
            errors++;
            $display("FAIL preload: got %0d:%0d:%0d mode %0d expected 23:59:0 mode 0",
                     ore, minute, secunde, mode);
        end
        repeat (2) do_tick1();
        checks++;
        if ({ore, minute, secunde} !== {5'd23, 6'd59, 6'd2}) begin
            errors++;
            $display("FAIL preload_run: got %0d:%0d:%0d expected 23:59:2", ore, minute, secunde);
        end
        repeat (56) do_tick1();
        checks++;
        if ({ore, minute, secunde} !== {5'd23, 6'd59, 6'd58}) begin
            errors++;
            $display("FAIL pre_roll: got %0d:%0d:%0d expected 23:59:58", ore, minute, secunde);
        end
        do_tick1();
        ccc[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c == 6) ccc[1] = 1'b0;
            wait_cyc(1);
            t = {ore, minute, secunde};
            checks++;
            if (t !== {5'd23, 6'd59, 6'd59} && t !== 17'd0) begin
                errors++;
                $display("FAIL roll_atomic: cycle %0d got %0d:%0d:%0d expected 23:59:59 or 0:0:0",
                         c, ore, minute, secunde);
            end
        end
        model_tick1();
        checks++;
        if (obs !== exp_vec() || {ore, minute, secunde} !== 17'd0) begin
            errors++;
            $display("FAIL rollover: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_autorepeat();
        bit prev;
        apply_reset();
        repeat (3) do_tick1();
        press_mode();
        repeat (22) press_plus();
        plus_down();
        for (int i = 0; i < 6; i++) begin
            prev = blink;
            do_tick2();
            checks++;
            if (blink !== !prev) begin
                errors++;
                $display("FAIL blink_toggle: step %0d got %b expected %b", i, blink, !prev);
            end
            if (i == 2) do_tick1();
        end
        plus_up();
        checks++;
        if ({ore, secunde} !== {5'd5, 6'd3}) begin
            errors++;
            $display("FAIL autorepeat: got ore %0d sec %0d expected ore 5 sec 3", ore, secunde);
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL autorepeat_model: got %h expected %h", obs, exp_vec());
        end
        repeat (4) press_mode();
        checks++;
        if ({mode, blink} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL back_to_run: got mode %0d blink %b expected mode 0 blink 0", mode, blink);
        end
    endtask

    task automatic test_alarm_stop();
        int n;
        alarm_setup(1'b1);
        do_tick1();
        checks++;
        if (alarm_active !== 1'b1 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL alarm_trigger: got %h expected %h", obs, exp_vec());
        end
        set_tone(1'b1);
        checks++;
        if (buzzer !== 1'b1) begin
            errors++;
            $display("FAIL buzzer_high: got %b expected 1", buzzer);
        end
        set_tone(1'b0);
        checks++;
        if (buzzer !== 1'b0) begin
            errors++;
            $display("FAIL buzzer_low: got %b expected 0", buzzer);
        end
        set_tone(1'b1);
        bs = 1'b1;
        n = 0;
        while (alarm_active === 1'b1 && n < 10) begin
            wait_cyc(1);
            n++;
        end
        checks++;
        if (n > 4 || buzzer !== 1'b0) begin
            errors++;
            $display("FAIL stop_latency: got %0d cycles buzzer %b expected <=4 cycles buzzer 0",
                     n, buzzer);
        end
        bs = 1'b0;
        wait_cyc(12);
        m_active = 0;
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL stop_model: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_timeout();
        alarm_setup(1'b1);
        do_tick1();
        for (int k = 1; k <= 60; k++) begin
            do_tick1();
            checks++;
            if (alarm_active !== (k < 60)) begin
                errors++;
                $display("FAIL timeout: tick %0d got %b expected %b", k, alarm_active, k < 60);
            end
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL timeout_model: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_no_trigger();
        alarm_setup(1'b0);
        do_tick1();
        checks++;
        if (alarm_active !== 1'b0 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL no_trigger: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_reset_ring();
        alarm_setup(1'b1);
        do_tick1();
        set_tone(1'b1);
        checks++;
        if (buzzer !== 1'b1) begin
            errors++;
            $display("FAIL ring_before_reset: got %b expected 1", buzzer);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (obs !== 34'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", obs, 34'd0);
        end
        apply_reset();
    endtask

    task automatic test_coincident();
        apply_reset();
        press_mode();
        repeat (3) press_plus();
        ccc[0] = 1'b1;
        bp     = 1'b1;
        wait_cyc(6);
        ccc[0] = 1'b0;
        bp     = 1'b0;
        wait_cyc(12);
        m_blink = !m_blink;
        inc_field();
        checks++;
        if (ore !== 5'd4 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL coincident: got %h expected %h", obs, exp_vec());
        end
        repeat (4) press_mode();
    endtask

    task automatic test_random();
        int h, mi, r;
        apply_reset();
        h  = $urandom_range(0, 23);
        mi = $urandom_range(0, 58);
        set_all(h, mi, h, mi + 1);
        set_en(1'b1);
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 15);
            if (r <= 7) do_tick1();
            else if (r == 8) do_tick2();
            else if (r == 9) press_mode();
            else if (r == 10) begin
                if (m_plus) plus_up();
                else press_plus();
            end
            else if (r == 11) begin
                if (m_plus) plus_up();
                else plus_down();
            end
            else if (r == 12) press_stop();
            else if (r == 13) set_en(!m_en);
            else set_tone(!m_tone);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random: step %0d event %0d got %h expected %h", i, r, obs, exp_vec());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ccc = 4'd0; bm = 0; bp = 0; bs = 0; en = 0;
        model_reset();
        wait_cyc(1);
        test_reset();
        test_count();
        test_preload_rollover();
        test_autorepeat();
        test_alarm_stop();
        test_timeout();
        test_no_trigger();
        test_reset_ring();
        test_coincident();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
